// File: rtl/rio_link_credit_framer.sv
// Link-layer framer: merges credit words, data and clock correction onto the
// 16-bit GTP lane (TX), and strips credits/idles back out of the lane (RX).
module rio_link_credit_framer #(
  parameter int                      CREDIT_WIDTH = 16,
  parameter int                      CC_PERIOD    = 5000,
  parameter logic [CREDIT_WIDTH-1:0] K_IDLE       = 16'hBC50,
  parameter logic [CREDIT_WIDTH-1:0] K_CRED       = 16'hFC00,
  parameter logic [CREDIT_WIDTH-1:0] K_CC         = 16'h1C1C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CREDIT_WIDTH-1:0] i_tx_data,
  input  logic                    i_tx_data_valid,
  output logic                    o_tx_data_ready,
  input  logic [CREDIT_WIDTH-1:0] i_us_credit,
  input  logic                    i_us_credit_valid,
  output logic                    o_us_credit_accept,
  output logic [CREDIT_WIDTH-1:0] o_gtp_txdata,
  output logic [1:0]              o_gtp_txcharisk,
  input  logic [CREDIT_WIDTH-1:0] i_gtp_rxdata,
  input  logic [1:0]              i_gtp_rxcharisk,
  input  logic                    i_gtp_rx_ok,
  output logic [CREDIT_WIDTH-1:0] o_rx_data,
  output logic                    o_rx_data_valid,
  output logic [CREDIT_WIDTH-1:0] o_ds_credit,
  output logic                    o_ds_credit_valid,
  output logic                    o_rx_error
);

  localparam logic [15:0] CC_LAST = 16'(CC_PERIOD - 1);

  typedef enum logic [1:0] {TX_NORM, TX_CRED, TX_CC2} tx_state_t;
  typedef enum logic       {RX_NORM, RX_CRED}         rx_state_t;

  tx_state_t               r_tx_state, w_tx_nxt;
  rx_state_t               r_rx_state, w_rx_nxt;
  logic [15:0]             r_cc_cnt;
  logic                    r_cc_pending;
  logic                    w_cc_clr;
  logic [CREDIT_WIDTH-1:0] w_tx_word;
  logic [1:0]              w_tx_k;

  // ---------------- TX ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc_cnt     <= '0;
      r_cc_pending <= 1'b0;
    end else begin
      r_cc_cnt <= (r_cc_cnt == CC_LAST) ? 16'd0 : r_cc_cnt + 16'd1;
      if (r_cc_cnt == CC_LAST) r_cc_pending <= 1'b1;
      else if (w_cc_clr)       r_cc_pending <= 1'b0;
    end
  end

  always_comb begin
    w_tx_nxt  = r_tx_state;
    w_tx_word = K_IDLE;
    w_tx_k    = 2'b10;
    w_cc_clr  = 1'b0;
    case (r_tx_state)
      TX_NORM: begin
        if (r_cc_pending) begin
          w_tx_word = K_CC;
          w_tx_k    = 2'b11;
          w_cc_clr  = 1'b1;
          w_tx_nxt  = TX_CC2;
        end else if (i_us_credit_valid) begin
          w_tx_word = K_CRED;
          w_tx_nxt  = TX_CRED;
        end else if (i_tx_data_valid) begin
          w_tx_word = i_tx_data;
          w_tx_k    = 2'b00;
        end
      end
      TX_CC2: begin
        w_tx_word = K_CC;
        w_tx_k    = 2'b11;
        w_tx_nxt  = TX_NORM;
      end
      TX_CRED: begin
        w_tx_word = i_us_credit;
        w_tx_k    = 2'b00;
        w_tx_nxt  = TX_NORM;
      end
      default: w_tx_nxt = TX_NORM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state      <= TX_NORM;
      o_gtp_txdata    <= K_IDLE;
      o_gtp_txcharisk <= 2'b10;
    end else begin
      r_tx_state      <= w_tx_nxt;
      o_gtp_txdata    <= w_tx_word;
      o_gtp_txcharisk <= w_tx_k;
    end
  end

  // Ready must track the live credit request so a credit always beats data.
  assign o_tx_data_ready    = !rst && (r_tx_state == TX_NORM) && !r_cc_pending
                              && !i_us_credit_valid;
  assign o_us_credit_accept = (r_tx_state == TX_CRED);

  // ---------------- RX ----------------
  logic w_is_data, w_is_mark, w_is_idle, w_is_cc;
  logic w_dv, w_cv, w_err;

  assign w_is_data = (i_gtp_rxcharisk == 2'b00);
  assign w_is_mark = (i_gtp_rxcharisk == 2'b10) && (i_gtp_rxdata == K_CRED);
  assign w_is_idle = (i_gtp_rxcharisk == 2'b10) && (i_gtp_rxdata == K_IDLE);
  assign w_is_cc   = (i_gtp_rxcharisk == 2'b11) && (i_gtp_rxdata == K_CC);

  always_comb begin
    w_rx_nxt = r_rx_state;
    w_dv     = 1'b0;
    w_cv     = 1'b0;
    w_err    = 1'b0;
    if (!i_gtp_rx_ok) begin
      w_rx_nxt = RX_NORM;
    end else if (r_rx_state == RX_CRED && w_is_data) begin
      w_cv     = 1'b1;
      w_rx_nxt = RX_NORM;
    end else begin
      // A K char inside a credit pair flags the broken pair, then is handled
      // like any other word outside a pair.
      w_err    = (r_rx_state == RX_CRED);
      w_rx_nxt = RX_NORM;
      if (w_is_data)                    w_dv     = 1'b1;
      else if (w_is_mark)               w_rx_nxt = RX_CRED;
      else if (!(w_is_idle || w_is_cc)) w_err    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state        <= RX_NORM;
      o_rx_data         <= '0;
      o_rx_data_valid   <= 1'b0;
      o_ds_credit       <= '0;
      o_ds_credit_valid <= 1'b0;
      o_rx_error        <= 1'b0;
    end else begin
      r_rx_state        <= w_rx_nxt;
      o_rx_data_valid   <= w_dv;
      o_ds_credit_valid <= w_cv;
      o_rx_error        <= w_err;
      if (w_dv) o_rx_data   <= i_gtp_rxdata;
      if (w_cv) o_ds_credit <= i_gtp_rxdata;
    end
  end

endmodule

// File: tb/tb_rio_link_credit_framer.sv
// Bench for rio_link_credit_framer: random TX traffic in loopback against a
// queue-based lane model, directed RX framing cases and a mid-credit reset.
module tb_rio_link_credit_framer;
  localparam int          CCP = 16;
  localparam logic [15:0] KI  = 16'hBC50;
  localparam logic [15:0] KC  = 16'hFC00;
  localparam logic [15:0] KX  = 16'h1C1C;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] tx_d = '0, cred = '0;
  logic        tx_v = 1'b0, cred_v = 1'b0;
  logic        o_tx_data_ready, o_us_credit_accept;
  logic [15:0] o_gtp_txdata, o_rx_data, o_ds_credit;
  logic [1:0]  o_gtp_txcharisk;
  logic        o_rx_data_valid, o_ds_credit_valid, o_rx_error;
  logic        lb = 1'b1, rx_ok = 1'b1;
  logic [15:0] drv_d = KI, rxd;
  logic [1:0]  drv_k = 2'b10, rxk;

  assign rxd = lb ? o_gtp_txdata    : drv_d;
  assign rxk = lb ? o_gtp_txcharisk : drv_k;

  always #5 clk = ~clk;

  rio_link_credit_framer #(.CC_PERIOD(CCP)) dut (
    .clk(clk), .rst(rst),
    .i_tx_data(tx_d), .i_tx_data_valid(tx_v), .o_tx_data_ready(o_tx_data_ready),
    .i_us_credit(cred), .i_us_credit_valid(cred_v), .o_us_credit_accept(o_us_credit_accept),
    .o_gtp_txdata(o_gtp_txdata), .o_gtp_txcharisk(o_gtp_txcharisk),
    .i_gtp_rxdata(rxd), .i_gtp_rxcharisk(rxk), .i_gtp_rx_ok(rx_ok),
    .o_rx_data(o_rx_data), .o_rx_data_valid(o_rx_data_valid),
    .o_ds_credit(o_ds_credit), .o_ds_credit_valid(o_ds_credit_valid),
    .o_rx_error(o_rx_error));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Lane model: committed multi-word sequences sit in m_seq and always go out
  // before any new selection is made.
  typedef struct packed {logic [15:0] d; logic [1:0] k; logic pay;} lw_t;
  lw_t         m_seq[$];
  int          m_cnt;
  bit          m_pend, e_ready, e_acc, m_cons;
  logic [15:0] exp_d = KI;
  logic [1:0]  exp_k = 2'b10;
  logic [15:0] q_data[$], q_cred[$];

  task automatic model_step();
    lw_t w;
    e_acc   = 0;
    m_cons  = 0;
    e_ready = (m_seq.size() == 0) && !m_pend && !cred_v;
    if (m_seq.size() != 0) begin
      w = m_seq.pop_front();
      if (w.pay) begin e_acc = 1; q_cred.push_back(w.d); end
    end else if (m_pend) begin
      w = '{KX, 2'b11, 1'b0};
      m_seq.push_back('{KX, 2'b11, 1'b0});
      m_pend = 0;
    end else if (cred_v) begin
      w = '{KC, 2'b10, 1'b0};
      m_seq.push_back('{cred, 2'b00, 1'b1});
    end else if (tx_v) begin
      w = '{tx_d, 2'b00, 1'b0};
      m_cons = 1;
      q_data.push_back(tx_d);
    end else begin
      w = '{KI, 2'b10, 1'b0};
    end
    if (m_cnt == CCP - 1) begin m_cnt = 0; m_pend = 1; end
    else m_cnt++;
    exp_d = w.d;
    exp_k = w.k;
  endtask

  typedef struct packed {
    logic [15:0] d; logic [1:0] k; logic ok; logic dv; logic cv; logic err; logic [15:0] v;
  } rxs_t;
  rxs_t tbl[$];

  initial begin
    logic [15:0] next_val;
    bit          prev_acc, prev_cons, found;
    next_val  = 16'h0001;
    prev_acc  = 0;
    prev_cons = 0;

    // reset values
    @(negedge clk);
    chk("rst_lane",  {o_gtp_txcharisk, o_gtp_txdata}, {2'b10, KI});
    chk("rst_hs",    {o_tx_data_ready, o_us_credit_accept}, 2'b00);
    chk("rst_strb",  {o_rx_data_valid, o_ds_credit_valid, o_rx_error}, 3'b000);
    chk("rst_rxd",   {o_rx_data, o_ds_credit}, 32'h0);

    @(posedge clk); #2 rst = 1'b0;
    m_cnt = 0; m_pend = 0; m_seq.delete();

    // random loopback traffic, then a drain with no new requests
    for (int cyc = 0; cyc < 3030; cyc++) begin
      @(negedge clk);
      chk("lane", {o_gtp_txcharisk, o_gtp_txdata}, {exp_k, exp_d});
      chk("rx_err", o_rx_error, 1'b0);
      if (o_rx_data_valid) begin
        if (q_data.size() == 0) chk("rx_data_extra", 1, 0);
        else chk("rx_data", o_rx_data, q_data.pop_front());
      end
      if (o_ds_credit_valid) begin
        if (q_cred.size() == 0) chk("ds_cred_extra", 1, 0);
        else chk("ds_cred", o_ds_credit, q_cred.pop_front());
      end
      if (prev_acc)  cred_v = 1'b0;
      if (prev_cons) tx_v   = 1'b0;
      if (cyc < 3000) begin
        if (!cred_v && $urandom_range(0, 9) == 0) begin
          cred_v = 1'b1;
          cred   = 16'($urandom);
        end
        if (!tx_v && $urandom_range(0, 3) != 0) begin
          tx_v = 1'b1;
          tx_d = next_val;
          next_val++;
        end
      end
      #1;
      model_step();
      chk("ready",  o_tx_data_ready,    e_ready);
      chk("accept", o_us_credit_accept, e_acc);
      prev_acc  = e_acc;
      prev_cons = m_cons;
    end
    chk("data_left", q_data.size(), 0);
    chk("cred_left", q_cred.size(), 0);

    // directed RX framing
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{KI,      2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{16'h1234,2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234});
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{16'h9003,2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h9003});
    tbl.push_back('{KX,      2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{KX,      2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{16'h5A5A,2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{16'h0BEE,2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0BEE});
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{16'h7777,2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{16'h4321,2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4321});
    tbl.push_back('{KI,      2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{KC,      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{16'h2222,2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0});
    lb = 1'b0;
    foreach (tbl[i]) begin
      drv_d = tbl[i].d;
      drv_k = tbl[i].k;
      rx_ok = tbl[i].ok;
      @(negedge clk);
      chk($sformatf("rx_strb%0d", i), {o_rx_data_valid, o_ds_credit_valid, o_rx_error},
          {tbl[i].dv, tbl[i].cv, tbl[i].err});
      if (tbl[i].dv) chk($sformatf("rx_dat%0d", i), o_rx_data, tbl[i].v);
      if (tbl[i].cv) chk($sformatf("rx_crd%0d", i), o_ds_credit, tbl[i].v);
    end
    chk("ds_hold", o_ds_credit, 16'h0BEE);
    drv_d = KI; drv_k = 2'b10; rx_ok = 1'b1;

    // reset in the middle of a credit pair
    lb = 1'b1;
    @(negedge clk);
    cred = 16'hABCD; cred_v = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_us_credit_accept) found = 1;
    end
    chk("acc_timeout", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_lane", {o_gtp_txcharisk, o_gtp_txdata}, {2'b10, KI});
    chk("arst_acc",  o_us_credit_accept, 1'b0);
    chk("arst_rdy",  o_tx_data_ready,    1'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rel_idle", {o_gtp_txcharisk, o_gtp_txdata}, {2'b10, KI});
    @(negedge clk);
    chk("resend_mark", {o_gtp_txcharisk, o_gtp_txdata}, {2'b10, KC});
    chk("resend_acc",  o_us_credit_accept, 1'b1);
    @(negedge clk);
    cred_v = 1'b0;
    chk("resend_pay", {o_gtp_txcharisk, o_gtp_txdata}, {2'b00, 16'hABCD});
    chk("resend_acc0", o_us_credit_accept, 1'b0);
    @(negedge clk);
    chk("resend_rx", {o_ds_credit_valid, o_ds_credit}, {1'b1, 16'hABCD});
    @(negedge clk);
    chk("resend_rx1", o_ds_credit_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rio_link_credit_framer.md
Name: rio_link_credit_framer

Overview:
- Link-layer framer between the per-VC credit logic and the GTP 16-bit lane.
- TX path: merges upstream credit words (16-bit, parity/VC-one-hot/value format) and outgoing data words into the GTP stream. Periodically inserts clock-correction sequences.
- RX path: strips credit words and idles from the received stream, presents credits to the credit logic, forwards data words.

Parameters:
- CREDIT_WIDTH, 16, credit and lane word width.
- CC_PERIOD, 5000, cycles between clock-correction insertions (counter width 16).
- K_IDLE, 16'hBC50, idle word; charisk 2'b10.
- K_CRED, 16'hFC00, credit marker word; charisk 2'b10.
- K_CC, 16'h1C1C, clock-correction word; charisk 2'b11.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_tx_data  in  16  outgoing data word
- i_tx_data_valid  in  1  data word present
- o_tx_data_ready  out  1  data word consumed this cycle when valid&ready
- i_us_credit  in  16  credit word to send
- i_us_credit_valid  in  1  credit present; held stable until accepted
- o_us_credit_accept  out  1  credit consumed this cycle
- o_gtp_txdata  out  16  lane word to GTP
- o_gtp_txcharisk  out  2  K flags, bit1 = upper byte
- i_gtp_rxdata  in  16  received lane word
- i_gtp_rxcharisk  in  2  received K flags
- i_gtp_rx_ok  in  1  lane aligned and locked
- o_rx_data  out  16  received data word
- o_rx_data_valid  out  1  data word strobe
- o_ds_credit  out  16  received credit word
- o_ds_credit_valid  out  1  one-cycle credit strobe
- o_rx_error  out  1  one-cycle framing error strobe

Behaviour:
- Reset (async assert, sync release):
  - o_gtp_txdata=K_IDLE, o_gtp_txcharisk=2'b10.
  - All strobes, accept and ready are 0; o_rx_data, o_ds_credit = 0.
  - CC counter = 0; both FSMs in their initial state.
- TX FSM states: TX_NORM, TX_CRED, TX_CC2. Outputs are registered: a word selected in cycle N appears on the lane in N+1.
- CC counter: increments every cycle; at CC_PERIOD-1 it sets cc_pending and wraps to 0.
- TX_NORM selection, priority cc_pending > credit > data > idle:
  - cc_pending: emit K_CC/2'b11, clear cc_pending, go to TX_CC2.
  - credit valid: emit K_CRED/2'b10, go to TX_CRED.
  - data valid: emit data/2'b00.
  - otherwise: emit K_IDLE/2'b10.
- TX_CC2: emit second K_CC/2'b11, return to TX_NORM. A CC pair is never split.
- TX_CRED: emit i_us_credit/2'b00, assert o_us_credit_accept for exactly this cycle, return to TX_NORM. Marker and payload are always back-to-back; CC is deferred until after the payload.
- o_tx_data_ready is combinational: high only in TX_NORM with no cc_pending and no i_us_credit_valid.
- Data words are never dropped or duplicated; the data source must hold its word while ready is 0.
- RX FSM states: RX_NORM, RX_CRED. Registered outputs, 1-cycle latency.
- RX_NORM, each word:
  - charisk 00: data word, pulse o_rx_data_valid.
  - K_CRED with charisk 10: go to RX_CRED.
  - K_IDLE or K_CC with correct charisk: discard.
  - Any other K combination: pulse o_rx_error.
- RX_CRED:
  - charisk 00: latch the word to o_ds_credit, pulse o_ds_credit_valid, return to RX_NORM. No parity check here; the credit logic performs it.
  - Any K char: pulse o_rx_error, drop the marker, reprocess this word as in RX_NORM.
- i_gtp_rx_ok low: RX FSM forced to RX_NORM, no strobes. Loss of lock mid-credit drops the credit silently.
- Simultaneous credit valid and data valid: credit wins; data stalls 2 cycles.
- Reset mid-sequence: a marker already on the lane without its payload is discarded by the far end through the error path.

Test Plan:
- Data only, valid held high for 10 words 0x0001..0x000A, CC_PERIOD large -> lane shows the same 10 words in order, charisk 00, 1-cycle latency, ready high throughout.
- Credit 0x9003 (valid) while data is streaming -> lane shows FC00/10 then 9003/00; accept high exactly 1 cycle; ready low for 2 cycles; no data word lost.
- CC_PERIOD=8 with a credit requested in the same cycle cc_pending rises -> lane shows 1C1C/11, 1C1C/11, FC00/10, credit/00.
- RX loopback of the TX output -> o_rx_data sequence equals the input data; o_ds_credit=0x9003 with a single valid strobe; idles and CC words not forwarded.
- RX input FC00/10 followed by BC50/10 -> o_rx_error pulses 1 cycle, no credit strobe, following data 0x1234/00 delivered normally.
- rst asserted mid-TX_CRED, asynchronously between clock edges -> outputs return to idle values immediately, accept 0; after release, the still-pending credit is resent as marker+payload.
